load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the byte-addressed rwmemory port. Accepts one load/store
//  request from the core (RV32 funct3 encoding), checks it, drives one memory
//  access cycle, sign/zero-extends load data, returns a registered response.
//  Sits between the execute stage and the data memory.
// PARAMETERS
//  MEMSIZE  'h400  memory size in bytes; must match attached rwmemory
//  DWIDTH   32     data width; only 32 supported
//  AWIDTH   $clog2(MEMSIZE) (localparam)  memory address width
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  reset          in   1       asynchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       unit can accept request (IDLE)
//  req_store      in   1       1=store, 0=load
//  req_funct3     in   3       000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   32      byte address
//  req_wdata      in   32      store data, LSB-aligned
//  rsp_valid      out  1       response present
//  rsp_ready      in   1       core accepts response
//  rsp_rdata      out  32      extended load data; 0 for stores and errors
//  rsp_err        out  1       misaligned / out-of-range / illegal funct3
//  mem_en         out  1       memory enable
//  mem_wen        out  1       memory write enable
//  mem_addr       out  AWIDTH  memory byte address
//  mem_data_in_w  out  3       write size code: 0 byte, 1 half, 2 word
//  mem_data_in    out  32      write data
//  mem_data_out   in   32      memory read data (combinational in memory)
// BEHAVIOUR
//  - FSM states IDLE, ACCESS, RESP. Reset -> IDLE; rsp_valid, rsp_err,
//    rsp_rdata, all mem_* outputs = 0; req_ready=0 while reset high.
//  - IDLE: req_ready=1. On req_valid at edge: latch store/funct3/addr/wdata.
//    Legal -> ACCESS; illegal -> RESP with rsp_err=1, no memory access.
//  - Illegal: funct3 in {011,110,111}; store with funct3[2]=1; H with
//    addr[0]!=0; W with addr[1:0]!=0; addr+bytes > MEMSIZE (compute in 33 b,
//    no wrap); any req_addr bit >= AWIDTH set.
//  - ACCESS (exactly 1 cycle): mem_en=1, mem_wen=store,
//    mem_addr=addr[AWIDTH-1:0], mem_data_in_w={1'b0,funct3[1:0]},
//    mem_data_in=wdata. Store commits at the edge ending ACCESS. Load samples
//    mem_data_out at that edge: B/H sign-extend bit 7/15, BU/HU zero-extend,
//    W pass-through; result registered into rsp_rdata. -> RESP.
//  - mem_* outputs are 0 in every state other than ACCESS.
//  - RESP: rsp_valid=1; rsp_rdata/rsp_err stable until rsp_valid&rsp_ready,
//    then -> IDLE, rsp_valid=0 next cycle. Accept-to-rsp_valid latency 2
//    cycles; max throughput 1 request per 3 cycles. No request accepted
//    while in ACCESS/RESP (req_ready=0).
//  - Reset mid-operation: async reset clears state and mem_en immediately;
//    no write commits after reset assertion; pending response dropped.
// STRUCTURE
//  - lsu_pkg: state enum (IDLE/ACCESS/RESP), funct3 constants, size-code
//    constants (SZ_B=0, SZ_H=1, SZ_W=2), byte-count function.
//  - Sub-module load_extend: combinational funct3 + raw word -> 32 b result.
//  - FSM, legality check, request/response registers in this module.
// TESTING (bench pairs with rwmemory, MEMSIZE='h400)
//  - SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF,
//    err=0, rsp_valid 2 cycles after accept; mem_en high exactly 1 cycle.
//  - After above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE;
//    LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
//  - SB 0x11 data 0x12345677 then LW 0x10 -> 0xDEAD77EF (only byte 1 changed).
//  - LW 0x11, LH 0x3FF, SW 0x3FE, LW 0x400, funct3=011, SB with funct3=100
//    -> each rsp_err=1, rsp_rdata=0, mem_en never asserted.
//  - Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable,
//    req_ready=0, new req_valid ignored; accepted only after handshake.
//  - Assert reset during ACCESS of SW 0x20 0xAAAAAAAA -> outputs 0 at once;
//    subsequent LW 0x20 returns prior contents.

Source files
------------

// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit:
//   - lsu_state_e : controller states (IDLE / ACCESS / RESP)
//   - F3_*        : RV32 load/store funct3 encodings
//   - SZ_*        : memory write size codes (byte / half / word)
//   - lsu_bytes() : number of bytes touched for a given size code
// ----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Size code 3 never reaches memory (rejected as illegal); it is mapped to 4
  // so the range check stays conservative.
  function automatic logic [2:0] lsu_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Combinational load-data formatter. The memory returns the word starting at
// the accessed byte address, so the wanted byte/half is always in the low
// bits; this block only sign- or zero-extends it.
//   i_funct3 : load funct3 (B, H, W, BU, HU)
//   i_raw    : raw 32-bit word from memory
//   o_result : extended 32-bit load result
// ----------------------------------------------------------------------------
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_result
);

  always_comb begin
    o_result = i_raw;
    case (i_funct3)
      F3_B:    o_result = {{24{i_raw[7]}},  i_raw[7:0]};
      F3_H:    o_result = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_BU:   o_result = {24'd0, i_raw[7:0]};
      F3_HU:   o_result = {16'd0, i_raw[15:0]};
      default: o_result = i_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the byte-addressed rwmemory port. Takes one load/store
// from the core, rejects illegal requests without touching memory, performs
// a single-cycle memory access for legal ones and returns a registered
// response that is held until the core accepts it.
//
// Ports
//   clk, reset              clock / asynchronous active-high reset
//   req_valid, req_ready    request handshake (ready only in IDLE)
//   req_store, req_funct3   operation: store flag + RV32 funct3
//   req_addr, req_wdata     byte address, LSB-aligned store data
//   rsp_valid, rsp_ready    response handshake
//   rsp_rdata, rsp_err      extended load data (0 for stores/errors), error
//   mem_en, mem_wen         memory enable / write enable (ACCESS only)
//   mem_addr                memory byte address
//   mem_data_in_w           write size code (0 byte, 1 half, 2 word)
//   mem_data_in             write data
//   mem_data_out            memory read data (combinational in memory)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a request; legal -> ACCESS, illegal -> RESP with err
// ACCESS | mem_en high for exactly one cycle; load data captured at its end
// RESP   | response held until rsp_valid & rsp_ready, then back to IDLE
// ----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEMSIZE = 'h400,
  parameter int DWIDTH  = 32,
  localparam int AWIDTH = $clog2(MEMSIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [2:0]        mem_data_in_w,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEMSIZE);

  lsu_state_e r_state;
  logic       r_store;
  logic [2:0] r_funct3;

  logic        w_f3_ok;
  logic        w_store_ok;
  logic        w_align_ok;
  logic        w_range_ok;
  logic        w_legal;
  logic [32:0] w_end;
  logic [31:0] w_ext;

  // ------------------------------------------------------------------
  // Request legality, evaluated on the live request inputs in IDLE
  // ------------------------------------------------------------------
  always_comb begin
    w_f3_ok = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: w_f3_ok = 1'b1;
      default:                        w_f3_ok = 1'b0;
    endcase
  end

  // Unsigned variants only exist for loads.
  assign w_store_ok = !(req_store && req_funct3[2]);

  always_comb begin
    w_align_ok = 1'b1;
    case (req_funct3[1:0])
      SZ_H:    w_align_ok = (req_addr[0] == 1'b0);
      SZ_W:    w_align_ok = (req_addr[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  // End address computed one bit wider so addresses near 2^32 cannot wrap
  // around and look in range.
  assign w_end      = {1'b0, req_addr} + {30'd0, lsu_bytes(req_funct3[1:0])};
  assign w_range_ok = (req_addr[31:AWIDTH] == '0) && (w_end <= MEM_LIMIT);

  assign w_legal = w_f3_ok && w_store_ok && w_align_ok && w_range_ok;

  // ------------------------------------------------------------------
  // Load data formatting
  // ------------------------------------------------------------------
  load_extend u_load_extend (
    .i_funct3 (r_funct3),
    .i_raw    (mem_data_out),
    .o_result (w_ext)
  );

  // Gated with reset so the core sees not-ready for the whole reset pulse.
  assign req_ready = (r_state == IDLE) && !reset;

  // ------------------------------------------------------------------
  // Controller with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_store       <= 1'b0;
      r_funct3      <= 3'd0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mem_en        <= 1'b0;
      mem_wen       <= 1'b0;
      mem_addr      <= '0;
      mem_data_in_w <= 3'd0;
      mem_data_in   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            if (w_legal) begin
              r_state       <= ACCESS;
              mem_en        <= 1'b1;
              mem_wen       <= req_store;
              mem_addr      <= req_addr[AWIDTH-1:0];
              mem_data_in_w <= {1'b0, req_funct3[1:0]};
              mem_data_in   <= req_wdata;
            end else begin
              r_state   <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        ACCESS: begin
          // Store commits and load data is sampled at this edge.
          r_state       <= RESP;
          rsp_valid     <= 1'b1;
          rsp_err       <= 1'b0;
          rsp_rdata     <= r_store ? '0 : w_ext;
          mem_en        <= 1'b0;
          mem_wen       <= 1'b0;
          mem_addr      <= '0;
          mem_data_in_w <= 3'd0;
          mem_data_in   <= '0;
        end

        RESP: begin
          if (rsp_ready) begin
            r_state   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_wen;
  logic [9:0]  mem_addr;
  logic [2:0]  mem_data_in_w;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.MEMSIZE('h400), .DWIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_en        (mem_en),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_data_in_w (mem_data_in_w),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural rwmemory: little-endian bytes, combinational read of the word
  // starting at mem_addr, sized write at the rising edge.
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  int en_cnt = 0;

  always_comb begin
    mem_data_out = '0;
    for (int i = 0; i < 4; i++)
      if (int'(mem_addr) + i < 1024)
        mem_data_out[8*i +: 8] = mem[int'(mem_addr) + i];
  end

  always @(posedge clk) begin
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_en && mem_wen) begin
      for (int i = 0; i < 4; i++) begin
        if ((i == 0) || (i == 1 && mem_data_in_w >= 3'd1) || (i >= 2 && mem_data_in_w == 3'd2))
          if (int'(mem_addr) + i < 1024)
            mem[int'(mem_addr) + i] <= mem_data_in[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic transact(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int ens);
    int en0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    en0 = en_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    rd  = rsp_rdata;
    er  = rsp_err;
    ens = en_cnt - en0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  // Runs one request and checks data, error flag, latency, memory cycles and
  // that the response drops after the handshake.
  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat, ens;
    transact(st, f3, a, wd, rd, er, lat, ens);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, " latency"}, lat, exp_err ? 32'd1 : 32'd2);
    check({tag, " mem_en cycles"}, ens, exp_err ? 32'd0 : 32'd1);
    @(negedge clk);
    check({tag, " rsp_valid drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int wait_n;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    rsp_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset req_ready", {31'd0, req_ready}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset mem_en", {31'd0, mem_en}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle req_ready", {31'd0, req_ready}, 32'd1);

    // Basic store/load and extension
    run("SW 0x10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    run("LW 0x10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    run("LB 0x13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    run("LBU 0x13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    run("LH 0x12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    run("LHU 0x10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    run("SB 0x11",  1'b1, 3'b000, 32'h11, 32'h12345677, 32'h0, 1'b0);
    run("LW after SB", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);
    run("SH 0x3FE", 1'b1, 3'b001, 32'h3FE, 32'h0000A5C3, 32'h0, 1'b0);
    run("LH 0x3FE", 1'b0, 3'b001, 32'h3FE, 32'h0, 32'hFFFFA5C3, 1'b0);
    run("LBU 0x3FF", 1'b0, 3'b100, 32'h3FF, 32'h0, 32'h000000A5, 1'b0);
    run("LW 0x3FC", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hA5C30000, 1'b0);

    // Illegal requests
    run("ERR LW 0x11",  1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1);
    run("ERR LH 0x3FF", 1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 1'b1);
    run("ERR SW 0x3FE", 1'b1, 3'b010, 32'h3FE, 32'h12345678, 32'h0, 1'b1);
    run("ERR LW 0x400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
    run("ERR f3 011",   1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1);
    run("ERR SB f3 100", 1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1);
    run("ERR high addr", 1'b0, 3'b000, 32'h80000010, 32'h0, 32'h0, 1'b1);
    run("LW unchanged", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD77EF, 1'b0);

    // Back-pressure: response held, new request ignored until handshake
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1 req_funct3 = 3'b100;
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!rsp_valid && wait_n < 20);
    check("hold first rsp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold rsp_rdata", rsp_rdata, 32'hDEAD77EF);
      check("hold req_ready", {31'd0, req_ready}, 32'd0);
      check("hold mem_en", {31'd0, mem_en}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("post hs rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post hs req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("pending accepted mem_en", {31'd0, mem_en}, 32'd1);
    check("pending accepted req_ready", {31'd0, req_ready}, 32'd0);
    wait_n = 0;
    do begin @(negedge clk); wait_n++; end while (!rsp_valid && wait_n < 20);
    check("pending LBU rdata", rsp_rdata, 32'h000000EF);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reset during ACCESS of a store
    run("SW 0x20 prior", 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("abort mem_en before reset", {31'd0, mem_en}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("abort mem_en", {31'd0, mem_en}, 32'd0);
    check("abort mem_wen", {31'd0, mem_wen}, 32'd0);
    check("abort mem_data_in", mem_data_in, 32'd0);
    check("abort rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    run("LW 0x20 after abort", 1'b0, 3'b010, 32'h20, 32'h0, 32'h11223344, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
